pkt_rx_ctrl: RTL and testbench
==============================

# pkt_rx_ctrl

Byte-stream receive controller that sequences the 4-byte word-assembly buffer and the downstream word RAM. It hunts for a header byte, gates exactly four payload bytes into the shift buffer, then issues one RAM write per assembled word with an auto-incrementing address. It sits between the byte-level receive front end and the shift buffer / RAM pair, all in the `clk_50` domain.

## Interface

- `ADDR_W`, 4: RAM address width; the RAM depth is 2^ADDR_W words.
- `HDR_A`, 8'hA5: first accepted header value; sets `hdr_type` = 0.
- `HDR_B`, 8'hC3: second accepted header value; sets `hdr_type` = 1.
- `TIMEOUT_CYC`, 64: idle-gap limit in cycles while collecting. Used only with `PKT_RX_CTRL_TIMEOUT_EN`.

Ports:

- `clk_50` in 1: the single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `byte_valid` in 1: one-cycle qualifier for `byte_in`.
- `byte_in` in 8: received byte.
- `buf_write_en` out 1: shift enable to the buffer (combinational).
- `buf_header_flag` out 1: header-accepted strobe to the buffer, which clears its full flag (combinational).
- `ram_wr` out 1: one-cycle RAM write strobe (registered).
- `ram_addr` out ADDR_W: RAM write address (registered).
- `hdr_type` out 1: header kind of the current packet (registered).
- `pkt_done` out 1: one-cycle pulse, coincident with `ram_wr`.
- `pkt_err` out 1: one-cycle pulse on timeout abort. Tied to 0 without the macro.
- `wrapped` out 1: sticky flag, set when `ram_addr` wraps from max to 0.

## Operation

- **FSM states:** IDLE, COLLECT, WRITE. The state register is 2 bits.
- **IDLE**
  - A byte with `byte_valid` = 1 and `byte_in` ∈ {HDR_A, HDR_B} is a header.
  - On a header: `buf_header_flag` = 1 in the same cycle, `hdr_type` is latched, byte count := 0, and the FSM goes to COLLECT.
  - Any other byte is dropped. `buf_write_en` stays 0.
- **COLLECT**
  - `buf_write_en` = `byte_valid`, in the same cycle, so the buffer samples `byte_in` directly.
  - The 2-bit byte count increments on each valid byte.
  - The 4th valid byte (count == 3) moves the FSM to WRITE.
  - Header values arriving in COLLECT are payload, not a resync.
- **WRITE**
  - Lasts exactly one cycle. `ram_wr` = 1 and `pkt_done` = 1, with `ram_addr` at the current address.
  - On exit, the address is incremented modulo 2^ADDR_W.
  - If the address was all-ones, `wrapped` is set and stays set until reset.
  - A header byte in the WRITE cycle is accepted as in IDLE (next state COLLECT, `buf_header_flag` = 1), so back-to-back packets have no dead cycle.
  - A non-header byte in WRITE is dropped; next state is IDLE.
- `buf_write_en` and `buf_header_flag` are never both 1 in the same cycle.
- **Reset** (asserted at any time, including mid-COLLECT): state = IDLE, count = 0, `ram_addr` = 0, and `ram_wr`, `pkt_done`, `pkt_err`, `hdr_type`, `wrapped` = 0. A partially shifted word is abandoned; the RAM is never written with it.

## Timing

- A header byte at cycle N puts the FSM in COLLECT at N+1.
- A payload byte's `buf_write_en` is asserted in the same cycle as its `byte_valid` (zero latency).
- When the 4th payload byte is at cycle M:
  - the buffer completes its shift at the M clock edge;
  - `ram_wr`/`pkt_done` are high during M+1, with the pre-increment `ram_addr`;
  - `ram_addr` shows the increment from M+2.
- Minimum packet period: 5 valid bytes (header + 4) per 5 cycles. Gaps between bytes are allowed.
- `byte_valid` held high for consecutive cycles counts as consecutive bytes.

## Configuration

- **`PKT_RX_CTRL_TIMEOUT_EN` defined:**
  - A gap counter of width $clog2(TIMEOUT_CYC+1) counts cycles in COLLECT with `byte_valid` = 0, and resets on each valid byte.
  - When it reaches TIMEOUT_CYC: `pkt_err` pulses 1 cycle, the FSM goes to IDLE, and there is no RAM write and no address change.
- **Not defined:** there is no gap counter, `pkt_err` is constant 0, and COLLECT waits indefinitely.

## Structure

- The shared package `pkt_rx_pkg` holds:
  - the `rx_state_t` enum (IDLE, COLLECT, WRITE);
  - the default header constants `PKT_HDR_A` = 8'hA5 and `PKT_HDR_B` = 8'hC3;
  - the localparam `BYTES_PER_WORD` = 4.
- A single module: the timeout counter lives inline under the macro. No sub-module.

## Test plan

- **Basic packet:** reset, then A5,11,22,33,44 on consecutive cycles.
  - Expect `buf_header_flag` with A5 and `buf_write_en` for the 4 payload bytes.
  - Expect `ram_wr` = 1 for 1 cycle with `ram_addr` = 0, `hdr_type` = 0, then `ram_addr` = 1.
- **Junk rejection:** 00,FF,5A in IDLE, then C3 + 4 bytes.
  - Expect no `buf_write_en` for the junk bytes and `hdr_type` = 1.
  - Expect `ram_wr` with `ram_addr` = 0.
- **Back-to-back:** A5,01,02,03,04 immediately followed by C3,05,06,07,08 (C3 lands in the WRITE cycle).
  - Expect two `ram_wr` pulses, addr 0 then 1, with no byte lost.
- **Header as payload:** A5,A5,C3,A5,C3.
  - Expect exactly 4 `buf_write_en` pulses and 1 `ram_wr`.
- **Wrap and mid-packet reset:**
  - With ADDR_W = 2, send 5 packets: expect addresses 0,1,2,3,0 and `wrapped` = 1 after the 4th write.
  - Assert `reset_n` after 2 payload bytes: expect all outputs 0, no `ram_wr`, and the next packet written at addr 0.
- **Timeout (macro on, TIMEOUT_CYC = 8):** A5,11, then an 8-cycle gap.
  - Expect a `pkt_err` pulse, no `ram_wr`, and the FSM back in IDLE.
  - A following A5 + 4 bytes is written at the unchanged address.

Source files
------------

// File: rtl/pkt_rx_pkg.sv
// Shared types and constants for the byte-stream receive controller.
package pkt_rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } rx_state_t;

    localparam logic [7:0] PKT_HDR_A      = 8'hA5;
    localparam logic [7:0] PKT_HDR_B      = 8'hC3;
    localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/pkt_rx_ctrl.sv
// Receive controller: hunts for a header, gates four payload bytes into the shift buffer,
// then writes the word to RAM at an auto-incrementing address. Option: PKT_RX_CTRL_TIMEOUT_EN.
module pkt_rx_ctrl
    import pkt_rx_pkg::*;
#(
    parameter int         ADDR_W      = 4,
    parameter logic [7:0] HDR_A       = PKT_HDR_A,
    parameter logic [7:0] HDR_B       = PKT_HDR_B,
    parameter int         TIMEOUT_CYC = 64
) (
    input  logic              clk_50,
    input  logic              reset_n,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic              buf_write_en,
    output logic              buf_header_flag,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              hdr_type,
    output logic              pkt_done,
    output logic              pkt_err,
    output logic              wrapped
);

    rx_state_t         r_state;
    rx_state_t         w_next;
    logic [1:0]        r_count;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_wr;
    logic              r_hdr_type;
    logic              r_wrapped;
    logic              w_is_hdr;
    logic              w_hdr_acc;
    logic              w_last_byte;
    logic              w_timeout;

    assign w_is_hdr    = byte_valid && (byte_in == HDR_A || byte_in == HDR_B);
    // WRITE accepts a header just like IDLE so back-to-back packets lose no cycle
    assign w_hdr_acc   = (r_state == IDLE || r_state == WRITE) && w_is_hdr;
    assign w_last_byte = byte_valid && (r_count == 2'(BYTES_PER_WORD - 1));

`ifdef PKT_RX_CTRL_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);
    logic [GAP_W-1:0] r_gap;
    logic             r_pkt_err;

    assign w_timeout = (r_state == COLLECT) && !byte_valid &&
                       (r_gap == GAP_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_gap     <= '0;
            r_pkt_err <= 1'b0;
        end else begin
            r_pkt_err <= w_timeout;
            if (r_state != COLLECT || byte_valid || w_timeout) r_gap <= '0;
            else                                                 r_gap <= r_gap + 1'b1;
        end
    end

    assign pkt_err = r_pkt_err;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYC > 0);
    assign w_timeout    = 1'b0;
    assign pkt_err      = 1'b0;
`endif

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_hdr_acc) w_next = COLLECT;
            COLLECT: begin
                if (w_timeout)        w_next = IDLE;
                else if (w_last_byte) w_next = WRITE;
            end
            WRITE:   w_next = w_hdr_acc ? COLLECT : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        buf_write_en    = 1'b0;
        buf_header_flag = 1'b0;
        case (r_state)
            COLLECT:     buf_write_en    = byte_valid;
            IDLE, WRITE: buf_header_flag = w_is_hdr;
            default:     ;
        endcase
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_count    <= '0;
            r_ram_addr <= '0;
            r_ram_wr   <= 1'b0;
            r_hdr_type <= 1'b0;
            r_wrapped  <= 1'b0;
        end else begin
            r_ram_wr <= (w_next == WRITE);
            if (w_hdr_acc) begin
                r_count    <= '0;
                r_hdr_type <= (byte_in == HDR_B);
            end else if (r_state == COLLECT && byte_valid) begin
                r_count <= r_count + 1'b1;
            end
            if (r_state == WRITE) begin
                r_ram_addr <= r_ram_addr + 1'b1;
                if (&r_ram_addr) r_wrapped <= 1'b1;
            end
        end
    end

    assign ram_wr   = r_ram_wr;
    assign pkt_done = r_ram_wr;
    assign ram_addr = r_ram_addr;
    assign hdr_type = r_hdr_type;
    assign wrapped  = r_wrapped;

endmodule

// File: tb/tb_pkt_rx_ctrl.sv
// Randomized self-checking bench for pkt_rx_ctrl against a stream-level reference model.
module tb_pkt_rx_ctrl;

`ifdef PKT_RX_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int AW  = 2;
    localparam int TOC = 8;

    logic       clk_50, reset_n, byte_valid;
    logic [7:0] byte_in;
    logic       buf_write_en, buf_header_flag, ram_wr, hdr_type, pkt_done, pkt_err, wrapped;
    logic [AW-1:0] ram_addr;

    pkt_rx_ctrl #(.ADDR_W(AW), .TIMEOUT_CYC(TOC)) dut (
        .clk_50(clk_50), .reset_n(reset_n), .byte_valid(byte_valid), .byte_in(byte_in),
        .buf_write_en(buf_write_en), .buf_header_flag(buf_header_flag), .ram_wr(ram_wr),
        .ram_addr(ram_addr), .hdr_type(hdr_type), .pkt_done(pkt_done), .pkt_err(pkt_err),
        .wrapped(wrapped)
    );

    initial clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    int checks = 0;
    int errors = 0;

    // reference model: packet-level view of the byte stream
    bit m_in_pkt, m_wr, m_err, m_hdr, m_wrapped;
    int m_nbytes, m_gap, m_addr;

    int we_cnt, hf_cnt, wr_cnt, err_cnt;
    int wr_addrs[$];
    bit wr_hdrs[$];

    task automatic model_clear();
        m_in_pkt = 0; m_wr = 0; m_err = 0; m_hdr = 0; m_wrapped = 0;
        m_nbytes = 0; m_gap = 0; m_addr = 0;
        we_cnt = 0; hf_cnt = 0; wr_cnt = 0; err_cnt = 0;
        wr_addrs.delete(); wr_hdrs.delete();
    endtask

    task automatic cycle(input logic v, input logic [7:0] b);
        bit hdr;
        @(negedge clk_50);
        byte_valid = v; byte_in = b;
        #1;
        hdr = v && (b == 8'hA5 || b == 8'hC3);
        checks++; if (buf_write_en !== (m_in_pkt && v)) begin errors++;
            $display("FAIL buf_write_en: got %b want %b (byte %h)", buf_write_en, m_in_pkt && v, b); end
        checks++; if (buf_header_flag !== (!m_in_pkt && hdr)) begin errors++;
            $display("FAIL buf_header_flag: got %b want %b (byte %h)", buf_header_flag, !m_in_pkt && hdr, b); end
        checks++; if (ram_wr !== m_wr) begin errors++;
            $display("FAIL ram_wr: got %b want %b", ram_wr, m_wr); end
        checks++; if (pkt_done !== m_wr) begin errors++;
            $display("FAIL pkt_done: got %b want %b", pkt_done, m_wr); end
        checks++; if (ram_addr !== AW'(m_addr)) begin errors++;
            $display("FAIL ram_addr: got %0d want %0d", ram_addr, m_addr); end
        checks++; if (hdr_type !== m_hdr) begin errors++;
            $display("FAIL hdr_type: got %b want %b", hdr_type, m_hdr); end
        checks++; if (wrapped !== m_wrapped) begin errors++;
            $display("FAIL wrapped: got %b want %b", wrapped, m_wrapped); end
        checks++; if (pkt_err !== m_err) begin errors++;
            $display("FAIL pkt_err: got %b want %b", pkt_err, m_err); end
        if (buf_write_en === 1'b1)    we_cnt++;
        if (buf_header_flag === 1'b1) hf_cnt++;
        if (pkt_err === 1'b1)         err_cnt++;
        if (ram_wr === 1'b1) begin
            wr_cnt++; wr_addrs.push_back(int'(ram_addr)); wr_hdrs.push_back(hdr_type);
        end
        // advance model to the values after the coming clock edge
        if (m_wr) begin
            if (m_addr == (1 << AW) - 1) m_wrapped = 1;
            m_addr = (m_addr + 1) % (1 << AW);
        end
        m_wr = 0; m_err = 0;
        if (m_in_pkt) begin
            if (v) begin
                m_gap = 0; m_nbytes++;
                if (m_nbytes == 4) begin m_in_pkt = 0; m_wr = 1; end
            end else if (TO_EN) begin
                m_gap++;
                if (m_gap == TOC) begin m_in_pkt = 0; m_err = 1; m_gap = 0; end
            end
        end else if (hdr) begin
            m_in_pkt = 1; m_nbytes = 0; m_gap = 0; m_hdr = (b == 8'hC3);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) cycle(1'b1, s[i]);
    endtask

    task automatic send_pkt(input logic [7:0] h, input int gmax);
        cycle(1'b1, h);
        for (int i = 0; i < 4; i++) begin
            idle($urandom_range(0, gmax));
            cycle(1'b1, 8'($urandom_range(0, 255)));
        end
    endtask

    task automatic test_reset();
        @(negedge clk_50);
        byte_valid = 1'b0; byte_in = 8'h00; reset_n = 1'b0;
        #1;
        checks++; if ({ram_wr, pkt_done, pkt_err, hdr_type, wrapped, buf_write_en, buf_header_flag} !== 7'b0
                      || ram_addr !== '0) begin errors++;
            $display("FAIL reset_outputs: got wr%b done%b err%b hdr%b wrap%b we%b hf%b addr%0d want all 0",
                     ram_wr, pkt_done, pkt_err, hdr_type, wrapped, buf_write_en, buf_header_flag, ram_addr); end
        model_clear();
        @(negedge clk_50);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        test_reset();
        send_seq('{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44});
        idle(2);
        checks++; if (hf_cnt != 1 || we_cnt != 4) begin errors++;
            $display("FAIL basic_strobes: got hf=%0d we=%0d want 1 4", hf_cnt, we_cnt); end
        checks++; if (wr_cnt != 1 || wr_addrs[0] != 0 || wr_hdrs[0] != 0) begin errors++;
            $display("FAIL basic_write: got n=%0d want 1 at addr 0 hdr 0", wr_cnt); end
        checks++; if (ram_addr !== 2'd1) begin errors++;
            $display("FAIL basic_addr_after: got %0d want 1", ram_addr); end
    endtask

    task automatic test_junk();
        test_reset();
        send_seq('{8'h00, 8'hFF, 8'h5A});
        checks++; if (we_cnt != 0 || hf_cnt != 0) begin errors++;
            $display("FAIL junk_dropped: got we=%0d hf=%0d want 0 0", we_cnt, hf_cnt); end
        send_seq('{8'hC3, 8'h01, 8'h02, 8'h03, 8'h04});
        idle(1);
        checks++; if (wr_cnt != 1 || wr_addrs[0] != 0 || wr_hdrs[0] != 1) begin errors++;
            $display("FAIL junk_write: got n=%0d want 1 at addr 0 hdr 1", wr_cnt); end
    endtask

    task automatic test_back_to_back();
        test_reset();
        send_seq('{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'hC3, 8'h05, 8'h06, 8'h07, 8'h08});
        idle(2);
        checks++; if (wr_cnt != 2 || wr_addrs[0] != 0 || wr_addrs[1] != 1 || wr_hdrs[1] != 1) begin errors++;
            $display("FAIL b2b_writes: got n=%0d want 2 at addr 0,1", wr_cnt); end
        checks++; if (we_cnt != 8 || hf_cnt != 2) begin errors++;
            $display("FAIL b2b_strobes: got we=%0d hf=%0d want 8 2", we_cnt, hf_cnt); end
    endtask

    task automatic test_hdr_payload();
        test_reset();
        send_seq('{8'hA5, 8'hA5, 8'hC3, 8'hA5, 8'hC3});
        idle(2);
        checks++; if (we_cnt != 4 || wr_cnt != 1 || hf_cnt != 1) begin errors++;
            $display("FAIL hdr_payload: got we=%0d wr=%0d hf=%0d want 4 1 1", we_cnt, wr_cnt, hf_cnt); end
    endtask

    task automatic test_wrap();
        test_reset();
        for (int p = 0; p < 3; p++) send_pkt(($urandom_range(0, 1) != 0) ? 8'hC3 : 8'hA5, 2);
        idle(2);
        checks++; if (wrapped !== 1'b0) begin errors++;
            $display("FAIL wrap_early: got %b want 0", wrapped); end
        send_pkt(8'hA5, 2);
        idle(2);
        checks++; if (wrapped !== 1'b1) begin errors++;
            $display("FAIL wrap_set: got %b want 1", wrapped); end
        send_pkt(8'hC3, 2);
        idle(2);
        checks++; if (wr_cnt != 5 || wr_addrs[0] != 0 || wr_addrs[1] != 1 || wr_addrs[2] != 2
                      || wr_addrs[3] != 3 || wr_addrs[4] != 0) begin errors++;
            $display("FAIL wrap_addrs: got n=%0d want 0,1,2,3,0", wr_cnt); end
    endtask

    task automatic test_mid_reset();
        test_reset();
        send_pkt(8'hC3, 1);
        idle(1);
        send_seq('{8'hA5, 8'h11, 8'h22});
        test_reset();
        idle(3);
        checks++; if (wr_cnt != 0) begin errors++;
            $display("FAIL midreset_no_write: got %0d writes want 0", wr_cnt); end
        send_seq('{8'hA5, 8'h31, 8'h32, 8'h33, 8'h34});
        idle(1);
        checks++; if (wr_cnt != 1 || wr_addrs[0] != 0) begin errors++;
            $display("FAIL midreset_next_addr: got n=%0d want 1 at addr 0", wr_cnt); end
    endtask

    task automatic test_random();
        test_reset();
        for (int i = 0; i < 400; i++) begin
            logic [7:0] b;
            case ($urandom_range(0, 5))
                0:       b = 8'hA5;
                1:       b = 8'hC3;
                default: b = 8'($urandom_range(0, 255));
            endcase
            cycle($urandom_range(0, 3) != 0, b);
        end
        idle(2);
    endtask

`ifdef PKT_RX_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        test_reset();
        send_pkt(8'hA5, 0);
        idle(1);
        send_seq('{8'hA5, 8'h11});
        idle(TOC + 4);
        checks++; if (err_cnt != 1 || wr_cnt != 1) begin errors++;
            $display("FAIL timeout_abort: got err=%0d wr=%0d want 1 1", err_cnt, wr_cnt); end
        send_seq('{8'hA5, 8'h21, 8'h22, 8'h23, 8'h24});
        idle(1);
        checks++; if (wr_cnt != 2 || wr_addrs[1] != 1) begin errors++;
            $display("FAIL timeout_next_addr: got n=%0d want 2nd write at addr 1", wr_cnt); end
    endtask
`endif

    initial begin
        reset_n = 1'b1; byte_valid = 1'b0; byte_in = 8'h00;
        model_clear();
        test_reset();
        test_basic();
        test_junk();
        test_back_to_back();
        test_hdr_payload();
        test_wrap();
        test_mid_reset();
        test_random();
`ifdef PKT_RX_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
